// File: rtl/dma_xfer_seq.sv
// DMA transfer sequencer: grant, CNET length fetch, PCI burst with retry/abort/timeout, TX wait, done.
// All outputs registered from next-state decode (one cycle after the deciding edge); requests are level-held.
module dma_xfer_seq #(
   parameter int RETRY_MAX    = 8,
   parameter int XFER_TIMEOUT = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic rd_req,
   input  logic wr_req,
   input  logic cnet_len_vld,
   input  logic pci_done,
   input  logic pci_retry,
   input  logic pci_abort,
   input  logic tx_wait_done,
   input  logic to_cnet_done,
   input  logic cnet_reprog,
   output logic xfer_is_rd,
   output logic pci_req,
   output logic dma_busy,
   output logic read_get_len,
   output logic write_start,
   output logic ld_dma_addr,
   output logic ld_xfer_cnt,
   output logic tx_wait_cnt_ld,
   output logic rd_undo,
   output logic rd_done,
   output logic wr_done,
   output logic xfer_err
);

   localparam int TW = $clog2(XFER_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_LEN  = 3'd1,
      LOAD    = 3'd2,
      XFER    = 3'd3,
      TX_WAIT = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic          last_rd_q, last_rd_d;
   logic [3:0]    retry_q, retry_d, retry_inc;
   logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
   logic          err_q, err_d;
   logic          is_rd_q, is_rd_d;
   logic          grant_rd;

   logic pci_req_q, pci_req_d;
   logic busy_q, busy_d;
   logic rgl_q, rgl_d;
   logic ws_q, ws_d;
   logic ld_addr_q, ld_addr_d;
   logic ld_cnt_q, ld_cnt_d;
   logic twl_q, twl_d;
   logic undo_q, undo_d;
   logic rdd_q, rdd_d;
   logic wrd_q, wrd_d;
   logic xerr_q, xerr_d;

   assign retry_inc = retry_q + 4'd1;
   assign tmo_inc   = (tmo_q == TW'(XFER_TIMEOUT)) ? tmo_q : tmo_q + 1'b1;
   // On contention the read wins unless the last completed transfer was a read.
   assign grant_rd  = rd_req && (!wr_req || !last_rd_q);

   always_comb begin
      state_d   = state_q;
      last_rd_d = last_rd_q;
      retry_d   = retry_q;
      tmo_d     = tmo_q;
      err_d     = err_q;
      is_rd_d   = is_rd_q;
      rgl_d     = 1'b0;
      ws_d      = 1'b0;
      twl_d     = 1'b0;
      undo_d    = 1'b0;
      rdd_d     = 1'b0;
      wrd_d     = 1'b0;
      xerr_d    = 1'b0;

      case (state_q)
         IDLE: begin
            is_rd_d = 1'b0;
            if (grant_rd) begin
               state_d = RD_LEN;
               is_rd_d = 1'b1;
            end else if (wr_req) begin
               state_d = LOAD;
               ws_d    = 1'b1;
            end
         end
         RD_LEN: begin
            if (cnet_len_vld) begin
               rgl_d   = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            tmo_d   = '0;
            state_d = XFER;
         end
         XFER: begin
            tmo_d = tmo_inc;
            if (pci_abort) begin
               xerr_d  = 1'b1;
               undo_d  = is_rd_q;
               err_d   = 1'b1;
               state_d = DONE;
            end else if (pci_done) begin
               if (is_rd_q) begin
                  state_d = DONE;
               end else begin
                  twl_d   = 1'b1;
                  state_d = TX_WAIT;
               end
            end else if (pci_retry) begin
               retry_d = retry_inc;
               if (retry_inc == 4'(RETRY_MAX)) begin
                  xerr_d  = 1'b1;
                  undo_d  = is_rd_q;
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = LOAD;
               end
            end else if (tmo_inc == TW'(XFER_TIMEOUT)) begin
               xerr_d  = 1'b1;
               undo_d  = is_rd_q;
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         TX_WAIT: begin
            if (tx_wait_done && to_cnet_done) begin
               state_d = DONE;
            end
         end
         DONE: begin
            rdd_d     = is_rd_q && !err_q;
            wrd_d     = !is_rd_q && !err_q;
            retry_d   = '0;
            err_d     = 1'b0;
            last_rd_d = is_rd_q;
            is_rd_d   = 1'b0;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Reprogramming kills the transfer silently; only an in-flight read must be undone.
      if (cnet_reprog) begin
         state_d   = IDLE;
         last_rd_d = last_rd_q;
         retry_d   = '0;
         tmo_d     = '0;
         err_d     = 1'b0;
         is_rd_d   = 1'b0;
         rgl_d     = 1'b0;
         ws_d      = 1'b0;
         twl_d     = 1'b0;
         rdd_d     = 1'b0;
         wrd_d     = 1'b0;
         xerr_d    = 1'b0;
         undo_d    = (state_q == XFER) && is_rd_q;
      end
   end

   assign ld_addr_d = (state_d == LOAD);
   assign ld_cnt_d  = (state_d == LOAD);
   assign pci_req_d = (state_d == XFER);
   assign busy_d    = (state_d != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         last_rd_q <= 1'b0;
         retry_q   <= '0;
         tmo_q     <= '0;
         err_q     <= 1'b0;
         is_rd_q   <= 1'b0;
         pci_req_q <= 1'b0;
         busy_q    <= 1'b0;
         rgl_q     <= 1'b0;
         ws_q      <= 1'b0;
         ld_addr_q <= 1'b0;
         ld_cnt_q  <= 1'b0;
         twl_q     <= 1'b0;
         undo_q    <= 1'b0;
         rdd_q     <= 1'b0;
         wrd_q     <= 1'b0;
         xerr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_rd_q <= last_rd_d;
         retry_q   <= retry_d;
         tmo_q     <= tmo_d;
         err_q     <= err_d;
         is_rd_q   <= is_rd_d;
         pci_req_q <= pci_req_d;
         busy_q    <= busy_d;
         rgl_q     <= rgl_d;
         ws_q      <= ws_d;
         ld_addr_q <= ld_addr_d;
         ld_cnt_q  <= ld_cnt_d;
         twl_q     <= twl_d;
         undo_q    <= undo_d;
         rdd_q     <= rdd_d;
         wrd_q     <= wrd_d;
         xerr_q    <= xerr_d;
      end
   end

   assign xfer_is_rd     = is_rd_q;
   assign pci_req        = pci_req_q;
   assign dma_busy       = busy_q;
   assign read_get_len   = rgl_q;
   assign write_start    = ws_q;
   assign ld_dma_addr    = ld_addr_q;
   assign ld_xfer_cnt    = ld_cnt_q;
   assign tx_wait_cnt_ld = twl_q;
   assign rd_undo        = undo_q;
   assign rd_done        = rdd_q;
   assign wr_done        = wrd_q;
   assign xfer_err       = xerr_q;

endmodule

// File: tb/tb_dma_xfer_seq.sv
// Scoreboard bench for dma_xfer_seq: scenarios push expected pulse events, a monitor pops and compares.
module tb_dma_xfer_seq;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rd_req = 1'b0, wr_req = 1'b0, cnet_len_vld = 1'b0;
   logic pci_done = 1'b0, pci_retry = 1'b0, pci_abort = 1'b0;
   logic tx_wait_done = 1'b0, to_cnet_done = 1'b0, cnet_reprog = 1'b0;
   logic xfer_is_rd, pci_req, dma_busy, read_get_len, write_start, ld_dma_addr, ld_xfer_cnt;
   logic tx_wait_cnt_ld, rd_undo, rd_done, wr_done, xfer_err;

   dma_xfer_seq dut (
      .clk(clk), .reset(reset), .rd_req(rd_req), .wr_req(wr_req), .cnet_len_vld(cnet_len_vld),
      .pci_done(pci_done), .pci_retry(pci_retry), .pci_abort(pci_abort),
      .tx_wait_done(tx_wait_done), .to_cnet_done(to_cnet_done), .cnet_reprog(cnet_reprog),
      .xfer_is_rd(xfer_is_rd), .pci_req(pci_req), .dma_busy(dma_busy), .read_get_len(read_get_len),
      .write_start(write_start), .ld_dma_addr(ld_dma_addr), .ld_xfer_cnt(ld_xfer_cnt),
      .tx_wait_cnt_ld(tx_wait_cnt_ld), .rd_undo(rd_undo), .rd_done(rd_done), .wr_done(wr_done),
      .xfer_err(xfer_err)
   );

   always #5 clk = ~clk;

   // Event = code*100000 + (xfer_is_rd, or 2*high-cycles of pci_req for PRF).
   localparam int WS = 1, RGL = 2, LD = 3, TWL = 4, ERR = 5, UNDO = 6, RDD = 7, WRD = 8;
   localparam int PRF = 9, BF = 10, LDX = 11;
   localparam int CYC_LIMIT = 20000;

   int checks = 0;
   int errors = 0;
   int stim_err = 0;
   bit stim_done = 1'b0;
   int exp_q[$];

   function automatic void ex(input int code, input int dir);
      exp_q.push_back(code * 100000 + dir);
   endfunction

   function automatic void exprf(input int run);
      exp_q.push_back(PRF * 100000 + run * 2);
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_req();
      for (int i = 0; i < 2000 && !pci_req; i++) @(negedge clk);
      if (!pci_req) begin
         stim_err++;
         $display("FAIL wait_pci_req got pci_req=0 required 1 within 2000 cycles");
      end
   endtask

   task automatic pulse_pci(input logic [2:0] kind, input int n);
      wait_req();
      repeat (n - 1) tick();
      pci_done  = kind[0];
      pci_retry = kind[1];
      pci_abort = kind[2];
      tick();
      pci_done  = 1'b0;
      pci_retry = 1'b0;
      pci_abort = 1'b0;
   endtask

   task automatic start_read();
      rd_req = 1'b1;
      tick();
      tick();
      cnet_len_vld = 1'b1;
      tick();
      cnet_len_vld = 1'b0;
   endtask

   task automatic observe(input int ev, input string nm);
      int e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s got event %0d required no event", nm, ev);
      end else begin
         e = exp_q.pop_front();
         if (e != ev) begin
            errors++;
            $display("FAIL %s got event %0d required %0d", nm, ev, e);
         end
      end
   endtask

   // Stimulus
   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      tick();

      // Contention after reset: read first, then write.
      ex(RGL, 1); ex(LD, 1); exprf(2); ex(RDD, 0); ex(BF, 0);
      ex(WS, 0); ex(LD, 0); ex(TWL, 0); exprf(1); ex(WRD, 0); ex(BF, 0);
      wr_req = 1'b1;
      start_read();
      pulse_pci(3'b001, 2);
      rd_req = 1'b0;
      pulse_pci(3'b001, 1);
      tick(); tick();
      tx_wait_done = 1'b1; to_cnet_done = 1'b1;
      tick();
      wr_req = 1'b0; tx_wait_done = 1'b0; to_cnet_done = 1'b0;
      repeat (3) tick();

      // Write only: pci_done 3 cycles into XFER, TX_WAIT needs both status bits.
      ex(WS, 0); ex(LD, 0); ex(TWL, 0); exprf(3); ex(WRD, 0); ex(BF, 0);
      wr_req = 1'b1;
      pulse_pci(3'b001, 3);
      repeat (2) tick();
      tx_wait_done = 1'b1;
      repeat (2) tick();
      to_cnet_done = 1'b1;
      tick();
      wr_req = 1'b0; tx_wait_done = 1'b0; to_cnet_done = 1'b0;
      repeat (3) tick();

      // Contention again: last completed was write, so read is granted.
      ex(RGL, 1); ex(LD, 1); exprf(1); ex(RDD, 0); ex(BF, 0);
      wr_req = 1'b1;
      start_read();
      pulse_pci(3'b001, 1);
      rd_req = 1'b0; wr_req = 1'b0;
      repeat (3) tick();

      // Read: 7 retries then done.
      ex(RGL, 1); ex(LD, 1);
      for (int i = 0; i < 7; i++) begin ex(LD, 1); exprf(1); end
      exprf(2); ex(RDD, 0); ex(BF, 0);
      start_read();
      for (int i = 0; i < 7; i++) pulse_pci(3'b010, 1);
      pulse_pci(3'b001, 2);
      rd_req = 1'b0;
      repeat (3) tick();

      // Read: 8th retry exhausts the budget.
      ex(RGL, 1); ex(LD, 1);
      for (int i = 0; i < 7; i++) begin ex(LD, 1); exprf(1); end
      ex(ERR, 1); ex(UNDO, 1); exprf(1); ex(BF, 0);
      start_read();
      for (int i = 0; i < 8; i++) pulse_pci(3'b010, 1);
      rd_req = 1'b0;
      repeat (3) tick();

      // Read: abort and done together, abort wins.
      ex(RGL, 1); ex(LD, 1); ex(ERR, 1); ex(UNDO, 1); exprf(2); ex(BF, 0);
      start_read();
      pulse_pci(3'b101, 2);
      rd_req = 1'b0;
      repeat (3) tick();

      // Read: no PCI response, timeout after 1024 XFER cycles.
      ex(RGL, 1); ex(LD, 1); ex(ERR, 1); ex(UNDO, 1); exprf(1024); ex(BF, 0);
      start_read();
      wait_req();
      for (int i = 0; i < 1200 && pci_req; i++) tick();
      if (pci_req) begin
         stim_err++;
         $display("FAIL timeout_exit got pci_req=1 required 0 within 1200 cycles");
      end
      rd_req = 1'b0;
      repeat (3) tick();

      // Reprogram during RD_LEN, held with rd_req pending: no grant, no pulses.
      ex(BF, 0);
      rd_req = 1'b1;
      tick(); tick();
      cnet_reprog = 1'b1;
      repeat (3) tick();
      rd_req = 1'b0;
      tick();
      cnet_reprog = 1'b0;
      repeat (2) tick();

      // Reprogram during read XFER: only rd_undo.
      ex(RGL, 1); ex(LD, 1); ex(UNDO, 0); exprf(2); ex(BF, 0);
      start_read();
      wait_req();
      tick();
      cnet_reprog = 1'b1; rd_req = 1'b0;
      tick();
      cnet_reprog = 1'b0;
      repeat (2) tick();

      // Reset mid-write: everything drops, no pulses.
      ex(WS, 0); ex(LD, 0); exprf(2); ex(BF, 0);
      wr_req = 1'b1;
      wait_req();
      tick();
      reset = 1'b1; wr_req = 1'b0;
      tick();
      reset = 1'b0;
      repeat (2) tick();

      // After reset, contention grants read again.
      ex(RGL, 1); ex(LD, 1); exprf(1); ex(RDD, 0); ex(BF, 0);
      wr_req = 1'b1;
      start_read();
      pulse_pci(3'b001, 1);
      rd_req = 1'b0; wr_req = 1'b0;
      repeat (4) tick();
      stim_done = 1'b1;
   end

   // Monitor
   initial begin
      logic prev_req, prev_busy;
      logic [11:0] outs;
      int run, cyc;
      prev_req = 1'b0; prev_busy = 1'b0; run = 0; cyc = 0;
      @(posedge clk); @(negedge clk);
      outs = {xfer_is_rd, pci_req, dma_busy, read_get_len, write_start, ld_dma_addr, ld_xfer_cnt,
              tx_wait_cnt_ld, rd_undo, rd_done, wr_done, xfer_err};
      checks++;
      if (outs !== 12'd0) begin
         errors++;
         $display("FAIL reset_outputs got %b required 000000000000", outs);
      end
      while (!stim_done && cyc < CYC_LIMIT) begin
         @(negedge clk);
         cyc++;
         if (write_start)    observe(WS * 100000 + int'(xfer_is_rd), "write_start");
         if (read_get_len)   observe(RGL * 100000 + int'(xfer_is_rd), "read_get_len");
         if (ld_dma_addr || ld_xfer_cnt)
            observe(((ld_dma_addr && ld_xfer_cnt) ? LD : LDX) * 100000 + int'(xfer_is_rd), "ld_pulses");
         if (tx_wait_cnt_ld) observe(TWL * 100000 + int'(xfer_is_rd), "tx_wait_cnt_ld");
         if (xfer_err)       observe(ERR * 100000 + int'(xfer_is_rd), "xfer_err");
         if (rd_undo)        observe(UNDO * 100000 + int'(xfer_is_rd), "rd_undo");
         if (rd_done)        observe(RDD * 100000 + int'(xfer_is_rd), "rd_done");
         if (wr_done)        observe(WRD * 100000 + int'(xfer_is_rd), "wr_done");
         if (pci_req) begin
            run++;
         end else if (prev_req) begin
            observe(PRF * 100000 + run * 2, "pci_req_fall");
            run = 0;
         end
         if (prev_busy && !dma_busy) observe(BF * 100000 + int'(xfer_is_rd), "busy_fall");
         prev_req  = pci_req;
         prev_busy = dma_busy;
      end
      checks++;
      if (cyc >= CYC_LIMIT) begin
         errors++;
         $display("FAIL run_length got %0d cycles required under %0d", cyc, CYC_LIMIT);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_events got %0d pending required 0", exp_q.size());
      end
      checks++;
      if (stim_err != 0) begin
         errors++;
         $display("FAIL stimulus_waits got %0d expired required 0", stim_err);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
